result_drain: RTL and testbench

//  Reads vector rows back out of the result BRAM (the port the SIMD core never reads) and streams them out.

---
 rtl/simd_pkg.sv | 15 +
 rtl/row_serializer.sv | 37 +++
 rtl/result_drain.sv | 117 +++++++++++
 tb/tb_result_drain.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared constants and state encoding for the SIMD result path.
package simd_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int PE_ELEMENTS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } drain_state_t;

endpackage

// File: rtl/row_serializer.sv
// Holds one captured result row and walks it out one lane at a time.
module row_serializer
    import simd_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int PE_ELEMENTS = PE_ELEMENTS_DEF
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              load,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] row_in,
    input  logic                              ready,
    output logic [DATA_WIDTH-1:0]             lane_data,
    output logic                              last_lane
);

    localparam int LANE_W = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;

    logic [PE_ELEMENTS*DATA_WIDTH-1:0] row_buf;
    logic [LANE_W-1:0]                 lane;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_buf <= '0;
            lane    <= '0;
        end else if (load) begin
            row_buf <= row_in;
            lane    <= '0;
        end else if (ready) begin
            lane <= last_lane ? '0 : lane + LANE_W'(1);
        end
    end

    assign last_lane = (lane == LANE_W'(PE_ELEMENTS - 1));
    assign lane_data = row_buf[int'(lane)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/result_drain.sv
// Reads rows from the result BRAM's spare port and streams them out lane by lane.
//   state | meaning
//   IDLE  | waiting for start; transfer parameters latched on start
//   FETCH | BRAM read issued for the current row
//   LOAD  | BRAM data captured into the serializer
//   SEND  | lanes of the row presented on the stream
//   DONE  | one-cycle completion pulse
module result_drain
    import simd_pkg::*;
#(
    parameter int  DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int  PE_ELEMENTS     = PE_ELEMENTS_DEF,
    parameter int  DRAM_DEPTH      = 256,
    localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [DRAM_ADDR_WIDTH-1:0]        base_addr,
    input  logic [DRAM_ADDR_WIDTH:0]          row_count,
    output logic                              ram_result_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]        ram_result_read_addr,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_result_read_data,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W = DRAM_ADDR_WIDTH + 1;

    drain_state_t                state, state_nxt;
    logic [DRAM_ADDR_WIDTH-1:0]  row_addr;
    logic [DRAM_ADDR_WIDTH-1:0]  next_addr;
    logic [CNT_W-1:0]            rows_left;
    logic                        accept;
    logic                        last_lane;
    logic [DATA_WIDTH-1:0]       lane_data;

    row_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PE_ELEMENTS (PE_ELEMENTS)
    ) u_row_serializer (
        .clk       (clk),
        .rstn      (rstn),
        .load      (state == LOAD),
        .row_in    (ram_result_read_data),
        .ready     (accept),
        .lane_data (lane_data),
        .last_lane (last_lane)
    );

    // Explicit wrap so non-power-of-two depths still stay inside the RAM.
    assign next_addr = (row_addr == DRAM_ADDR_WIDTH'(DRAM_DEPTH - 1)) ?
                       '0 : row_addr + DRAM_ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            row_addr  <= '0;
            rows_left <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                row_addr  <= base_addr;
                rows_left <= row_count;
            end else if (accept && last_lane) begin
                rows_left <= rows_left - CNT_W'(1);
                row_addr  <= next_addr;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        ram_result_rd_en = 1'b0;
        m_valid          = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (row_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                ram_result_rd_en = 1'b1;
                state_nxt        = LOAD;
            end
            LOAD: begin
                state_nxt = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready && last_lane) begin
                    state_nxt = (rows_left > CNT_W'(1)) ? FETCH : DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept               = m_valid && m_ready;
    assign ram_result_read_addr = row_addr;
    assign m_data               = m_valid ? lane_data : '0;
    assign m_last               = m_valid && last_lane && (rows_left == CNT_W'(1));

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: stimulus queues expected beats, a negedge monitor checks them.
module tb_result_drain;

    localparam int DW    = 32;
    localparam int PE    = 4;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW:0]    row_count = '0;
    logic           ram_result_rd_en;
    logic [AW-1:0]  ram_result_read_addr;
    logic [PE*DW-1:0] ram_result_read_data = '0;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic           m_last;
    logic           busy;
    logic           done;

    logic [PE*DW-1:0] mem [DEPTH];
    int unsigned      rd_log [$];
    beat_t            exp_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int rdy_mode = 0;
    int first_valid_k;
    int first_done_k;

    result_drain #(
        .DATA_WIDTH  (DW),
        .PE_ELEMENTS (PE),
        .DRAM_DEPTH  (DEPTH)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .start                (start),
        .base_addr            (base_addr),
        .row_count            (row_count),
        .ram_result_rd_en     (ram_result_rd_en),
        .ram_result_read_addr (ram_result_read_addr),
        .ram_result_read_data (ram_result_read_data),
        .m_data               (m_data),
        .m_valid              (m_valid),
        .m_ready              (m_ready),
        .m_last               (m_last),
        .busy                 (busy),
        .done                 (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_result_rd_en) begin
            ram_result_read_data <= mem[ram_result_read_addr];
            rd_log.push_back(32'(ram_result_read_addr));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = (rdy_mode == 0) ? 1'b1 : ~m_ready;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: beat compare, stall stability, done timing.
    logic          prev_ok = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            done_due = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (!rstn) begin
            prev_ok  = 1'b0;
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                chk("done_after_last", 64'(done), 64'(1));
                done_due = 1'b0;
            end
            if (done) done_cnt++;
            if (m_valid) begin
                chk("busy_with_valid", 64'(busy), 64'(1));
                chk("done_with_valid", 64'(done), 64'(0));
            end
            if (prev_ok && prev_valid && !prev_ready) begin
                chk("valid_held", 64'(m_valid), 64'(1));
                chk("data_held", 64'(m_data), 64'(prev_data));
                chk("last_held", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0d required=none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.data));
                    chk("beat_last", 64'(m_last), 64'(e.last));
                end
                beats_seen++;
                if (m_last) done_due = 1'b1;
            end
            prev_ok    = 1'b1;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic push_expected(input int base, input int cnt);
        beat_t b;
        for (int i = 0; i < cnt; i++) begin
            for (int l = 0; l < PE; l++) begin
                b.data = DW'(PE * ((base + i) % DEPTH) + l);
                b.last = (i == cnt - 1) && (l == PE - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start(input int base, input int cnt);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        row_count = (AW+1)'(cnt);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = '0;
        row_count = '0;
    endtask

    task automatic run_xfer(input int base, input int cnt, input int budget, input bit restart);
        int d0;
        int k;
        bit restarted;
        push_expected(base, cnt);
        rd_log.delete();
        d0            = done_cnt;
        first_valid_k = 0;
        restarted     = 1'b0;
        pulse_start(base, cnt);
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
            if (m_valid && first_valid_k == 0) first_valid_k = k;
            if (restart && first_valid_k != 0 && !restarted) begin
                start     = 1'b1;
                base_addr = AW'(7);
                row_count = (AW+1)'(3);
                restarted = 1'b1;
            end else if (start) begin
                start     = 1'b0;
                base_addr = '0;
                row_count = '0;
            end
        end
        first_done_k = k;
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("beats_left", 64'(exp_q.size()), 64'(0));
        chk("rd_count", 64'(rd_log.size()), 64'(cnt));
        for (int i = 0; i < rd_log.size() && i < cnt; i++)
            chk("rd_addr", 64'(rd_log[i]), 64'((base + i) % DEPTH));
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int b0;
        int k;
        for (int r = 0; r < DEPTH; r++)
            mem[r] = {DW'(4*r + 3), DW'(4*r + 2), DW'(4*r + 1), DW'(4*r)};
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_en", 64'(ram_result_rd_en), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        rstn = 1'b1;

        // two rows, sink always ready: 4 beats, 2-cycle bubble, 4 beats, done
        rdy_mode = 0;
        run_xfer(0, 2, 40, 1'b0);
        chk("t1_first_valid", 64'(first_valid_k), 64'(3));
        chk("t1_done_cycle", 64'(first_done_k), 64'(13));

        rdy_mode = 1;
        run_xfer(0, 2, 80, 1'b0);
        chk("t2_first_valid", 64'(first_valid_k), 64'(3));
        rdy_mode = 0;

        run_xfer(255, 2, 40, 1'b0);
        chk("t3_done_cycle", 64'(first_done_k), 64'(13));

        run_xfer(0, 0, 20, 1'b0);
        chk("t4_no_valid", 64'(first_valid_k), 64'(0));
        chk("t4_done_soon", 64'(first_done_k >= 1 && first_done_k <= 2), 64'(1));

        run_xfer(0, 256, 3000, 1'b0);
        chk("t4_full_done_cycle", 64'(first_done_k), 64'(256 * (PE + 2) + 1));

        run_xfer(0, 2, 40, 1'b1);
        chk("t5_done_cycle", 64'(first_done_k), 64'(13));

        // async reset while streaming row 2 of a 4-row transfer
        push_expected(0, 4);
        d0 = done_cnt;
        b0 = beats_seen;
        pulse_start(0, 4);
        k = 0;
        while (beats_seen - b0 < 9 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t6_reached_row2", 64'(beats_seen - b0 >= 9), 64'(1));
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_m_valid", 64'(m_valid), 64'(0));
        chk("t6_m_last", 64'(m_last), 64'(0));
        chk("t6_m_data", 64'(m_data), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        chk("t6_rd_en", 64'(ram_result_rd_en), 64'(0));
        chk("t6_read_addr", 64'(ram_result_read_addr), 64'(0));
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_xfer(0, 2, 40, 1'b0);
        chk("t6_clean_done_cycle", 64'(first_done_k), 64'(13));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
